// File: rtl/tqvp_dlmiles_i2c_txarb.sv
// Two-requester lock arbiter for the I2C TX FIFO push port.
// Owner keeps the port until its last word; idle owners time out.
module tqvp_dlmiles_i2c_txarb #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       owner_o,
  output logic [1:0]       abort_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OWN0 = 2'b01,
    S_OWN1 = 2'b10
  } state_t;

  state_t        r_state, w_state_n;
  logic          r_rr, w_rr_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [1:0]    r_abort, w_abort_n;

  logic w_own0, w_own1, w_own;
  logic w_sel_valid, w_sel_last;
  logic w_xfer, w_tmo;

  assign w_own0 = (r_state == S_OWN0);
  assign w_own1 = (r_state == S_OWN1);
  assign w_own  = w_own0 | w_own1;

  assign w_sel_valid = (w_own0 & req0_valid) | (w_own1 & req1_valid);
  assign w_sel_last  = (w_own0 & req0_last)  | (w_own1 & req1_last);

  // Flush gates the push so the FIFO cannot take a word it is dropping.
  assign m_valid    = w_sel_valid & ~flush_i;
  assign m_data     = w_own0 ? req0_data :
                      w_own1 ? req1_data : '0;
  assign req0_ready = w_own0 & m_ready & ~flush_i;
  assign req1_ready = w_own1 & m_ready & ~flush_i;

  assign w_xfer = m_valid & m_ready;
  assign w_tmo  = (TIMEOUT != 0) && w_own && (r_cnt == TMAX);

  assign owner_o = {w_own1, w_own0};
  assign abort_o = r_abort;

  // Next-state, priority pointer, idle counter and abort pulse.
  always_comb begin
    w_state_n = r_state;
    w_rr_n    = r_rr;
    w_cnt_n   = r_cnt;
    w_abort_n = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (req0_valid && req1_valid)
          w_state_n = r_rr ? S_OWN1 : S_OWN0;
        else if (req0_valid)
          w_state_n = S_OWN0;
        else if (req1_valid)
          w_state_n = S_OWN1;
      end
      S_OWN0, S_OWN1: begin
        if (w_xfer && w_sel_last) begin
          w_state_n = S_IDLE;
          w_rr_n    = w_own0;
          w_cnt_n   = '0;
        end else if (w_tmo) begin
          w_state_n = S_IDLE;
          w_rr_n    = w_own0;
          w_cnt_n   = '0;
          w_abort_n = {w_own1, w_own0};
        end else if (w_xfer) begin
          w_cnt_n = '0;
        end else if (!w_sel_valid && r_cnt != TMAX) begin
          w_cnt_n = r_cnt + ONE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
    if (flush_i) begin
      w_state_n = S_IDLE;
      w_rr_n    = r_rr;
      w_cnt_n   = '0;
      w_abort_n = 2'b00;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
      r_abort <= 2'b00;
    end else begin
      r_state <= w_state_n;
      r_rr    <= w_rr_n;
      r_cnt   <= w_cnt_n;
      r_abort <= w_abort_n;
    end
  end

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_txarb.sv
// Scoreboard bench for the TX push arbiter.
// Words are queued per requester when driven, popped on push.
module tb_tqvp_dlmiles_i2c_txarb;

  localparam int W  = 12;
  localparam int TO = 255;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i;
  logic         req0_valid, req0_last, req0_ready;
  logic [W-1:0] req0_data;
  logic         req1_valid, req1_last, req1_ready;
  logic [W-1:0] req1_data;
  logic         m_valid, m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   owner_o, abort_o;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int n_chk = 0;
  int n_pass = 0;

  tqvp_dlmiles_i2c_txarb #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .owner_o(owner_o), .abort_o(abort_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (owner_o == 2'b01) begin
        if (q0.size() == 0) check("q0_empty", 1, 0);
        else check("m_data0", m_data, q0.pop_front());
      end else if (owner_o == 2'b10) begin
        if (q1.size() == 0) check("q1_empty", 1, 0);
        else check("m_data1", m_data, q1.pop_front());
      end else begin
        check("xfer_owner", owner_o, 2'b01);
      end
    end
  end

  task automatic drive(input int n, input logic [W-1:0] d,
                       input logic l);
    if (n == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_last = l;
      q0.push_back(d);
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_last = l;
      q1.push_back(d);
    end
  endtask

  task automatic wait_acc(input int n, output int k);
    bit ok;
    ok = 0;
    k = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (n == 0 ? (req0_valid && req0_ready)
                 : (req1_valid && req1_ready)) begin
        ok = 1;
        check("own", owner_o, (n == 0) ? 2'b01 : 2'b10);
        check("excl", (n == 0) ? req1_ready : req0_ready, 0);
      end else begin
        k++;
      end
    end
    if (!ok) check("acc_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int k, ab, ab_i, acc_i, own_ab;
    rst_n = 1'b0; flush_i = 1'b0; m_ready = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    #12;
    check("rst_owner", owner_o, 0);
    check("rst_abort", abort_o, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_rdy", {req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;

    // single requester
    drive(0, 12'h100, 1'b0);
    @(negedge clk);
    check("t1_lat", owner_o, 0);
    wait_acc(0, k); check("t1_w0", k, 0);
    drive(0, 12'h0A5, 1'b0);
    wait_acc(0, k); check("t1_w1", k, 0);
    drive(0, 12'h8FF, 1'b1);
    wait_acc(0, k); check("t1_w2", k, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_idle", owner_o, 0);
    @(posedge clk); #1;

    // contention from reset
    rst_n = 1'b0;
    drive(0, 12'h101, 1'b0);
    drive(1, 12'h201, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_acc(0, k); check("t2_first", k, 1);
    drive(0, 12'h102, 1'b1);
    wait_acc(0, k); check("t2_last0", k, 0);
    req0_valid = 1'b0;
    wait_acc(1, k); check("t2_gap", k, 1);
    req1_valid = 1'b0;
    drive(0, 12'h103, 1'b1);
    drive(1, 12'h203, 1'b1);
    wait_acc(0, k); check("t2_rr", k, 1);
    req0_valid = 1'b0;
    wait_acc(1, k); check("t2_gap2", k, 1);
    req1_valid = 1'b0;

    // backpressure never aborts
    m_ready = 1'b0;
    drive(1, 12'h2AA, 1'b1);
    ab = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (abort_o != 2'b00) ab++;
    end
    check("bp_abort", ab, 0);
    check("bp_owner", owner_o, 2'b10);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_acc(1, k); check("bp_xfer", k, 0);
    req1_valid = 1'b0;

    // owner timeout with req1 pending
    drive(0, 12'h111, 1'b0);
    wait_acc(0, k);
    req0_valid = 1'b0;
    drive(1, 12'h2BB, 1'b1);
    ab = 0; ab_i = 0; acc_i = 0; own_ab = 3;
    for (int i = 1; i <= TO + 7; i++) begin
      @(negedge clk);
      if (abort_o == 2'b01) begin
        ab++;
        if (ab_i == 0) begin ab_i = i; own_ab = owner_o; end
      end else if (abort_o != 2'b00) begin
        ab += 100;
      end
      if (req1_valid && req1_ready) begin
        acc_i = i;
        @(posedge clk); #1;
        req1_valid = 1'b0;
      end
    end
    check("tmo_count", ab, 1);
    check("tmo_cycle", ab_i, TO + 2);
    check("tmo_owner", own_ab, 0);
    check("tmo_grant", acc_i, TO + 3);

    // last word in the threshold cycle
    drive(0, 12'h1CC, 1'b0);
    wait_acc(0, k);
    req0_valid = 1'b0;
    ab = 0;
    for (int i = 1; i <= TO + 4; i++) begin
      if (i == TO + 1) drive(0, 12'h1EE, 1'b1);
      @(negedge clk);
      if (abort_o != 2'b00) ab++;
      if (i == TO + 1) check("sim_acc", req0_ready, 1);
      @(posedge clk); #1;
      if (i == TO + 1) req0_valid = 1'b0;
    end
    check("sim_abort", ab, 0);
    check("sim_owner", owner_o, 0);

    // flush mid-transaction
    drive(0, 12'h155, 1'b0);
    wait_acc(0, k);
    req0_data = 12'h166;
    flush_i = 1'b1;
    @(negedge clk);
    check("fl_rdy", {req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    check("fl_owner", owner_o, 0);
    check("fl_abort", abort_o, 0);
    @(posedge clk); #1;

    // async reset mid-transaction
    drive(1, 12'h177, 1'b0);
    wait_acc(1, k);
    m_ready = 1'b0;
    req1_data = 12'h188;
    @(negedge clk);
    check("ar_pre", {owner_o, m_valid}, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    check("ar_owner", owner_o, 0);
    check("ar_mvalid", m_valid, 0);
    check("ar_mdata", m_data, 0);
    check("ar_rdy", {req1_ready, req0_ready}, 0);
    check("ar_abort", abort_o, 0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    m_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_after", owner_o, 0);

    check("q0_left", q0.size(), 0);
    check("q1_left", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
